// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite reader: FSM state encoding and pixel type.
package sprite_pkg;

    localparam int ADDR_W = 19;
    localparam int DATA_W = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } sr_state_t;

    typedef logic [DATA_W-1:0] pix_t;

endpackage

// File: rtl/pix_fifo2.sv
// Two-entry output FIFO holding {last, data}; head is the oldest entry.
module pix_fifo2 #(
    parameter int DATA_W = 24
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            push,
    input  logic [DATA_W:0] din,
    input  logic            pop,
    output logic [1:0]      count,
    output logic [DATA_W:0] head
);

    logic [DATA_W:0] mem [2];
    logic            wr_ptr, rd_ptr;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            count <= count + 2'(push) - 2'(pop);
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/sprite_reader.sv
// Streams a w x h sprite out of the spritesheet RAM in raster order, covering
// the RAM's 1-cycle read latency and downstream backpressure with a 2-entry FIFO.
module sprite_reader #(
    parameter int SHEET_W = 256,
    parameter int ADDR_W  = 19,
    parameter int DATA_W  = 24,
    parameter int DIM_W   = 6
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_x,
    input  logic [ADDR_W-1:0] req_y,
    input  logic [DIM_W-1:0]  req_w,
    input  logic [DIM_W-1:0]  req_h,
    output logic [ADDR_W-1:0] read_address,
    input  logic [DATA_W-1:0] rd_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_last,
    output logic              busy
);
    import sprite_pkg::*;

    sr_state_t         state, state_n;
    logic [DIM_W-1:0]  w_q, h_q, col, row;
    logic [ADDR_W-1:0] row_base, addr_q, cur_addr;
    logic              inflight, inflight_last;
    logic              accept, issue, pop, col_end, last_pos, drained;
    logic [1:0]        count;
    logic [DATA_W:0]   head;
    logic [2:0]        occ;

    assign pop      = pix_valid & pix_ready;
    // Slots committed after this cycle's pop; in-flight reads reserve a slot.
    assign occ      = 3'(count) + 3'(inflight) - 3'(pop);
    assign col_end  = (col == w_q - DIM_W'(1));
    assign last_pos = col_end && (row == h_q - DIM_W'(1));
    assign cur_addr = row_base + ADDR_W'(col);
    assign drained  = !inflight && (count == 2'd0 || (count == 2'd1 && pop));

    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        issue   = 1'b0;
        unique case (state)
            IDLE: begin
                accept = req_valid;
                if (req_valid && req_w != '0 && req_h != '0)
                    state_n = FETCH;
            end
            FETCH: begin
                issue = (occ < 3'd2);
                if (issue && last_pos)
                    state_n = DRAIN;
            end
            DRAIN: begin
                if (drained)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            w_q           <= '0;
            h_q           <= '0;
            col           <= '0;
            row           <= '0;
            row_base      <= '0;
            addr_q        <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            if (accept) begin
                w_q      <= req_w;
                h_q      <= req_h;
                row_base <= req_y * ADDR_W'(SHEET_W) + req_x;
                col      <= '0;
                row      <= '0;
            end
            // Row stepping is an add of the pitch; only the origin needs a multiply.
            if (issue) begin
                addr_q <= cur_addr;
                if (col_end) begin
                    col      <= '0;
                    row      <= row + DIM_W'(1);
                    row_base <= row_base + ADDR_W'(SHEET_W);
                end else begin
                    col <= col + DIM_W'(1);
                end
            end
            inflight      <= issue;
            inflight_last <= issue & last_pos;
        end
    end

    pix_fifo2 #(.DATA_W(DATA_W)) u_fifo (
        .Clk   (Clk),
        .Reset (Reset),
        .push  (inflight),
        .din   ({inflight_last, rd_data}),
        .pop   (pop),
        .count (count),
        .head  (head)
    );

    assign read_address = issue ? cur_addr : addr_q;
    assign req_ready    = (state == IDLE);
    assign busy         = (state != IDLE);
    assign pix_valid    = (count != 2'd0);
    assign pix_data     = pix_valid ? head[DATA_W-1:0] : '0;
    assign pix_last     = pix_valid & head[DATA_W];

endmodule
